mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one serial shift-add signed multiplier engine among N_REQ requesters.
//  Captures the granted requester's operands, pulses the engine start and waits for engine ready.
//  Returns the product to the granted requester with a one-hot valid pulse.
//  Sits between control-loop calculators and the single multiplier instance in the FPGA fabric.
// PARAMETERS
//  N_REQ    4    number of requesters, 2..8
//  WIDTH_A  16   operand A width; forwarded unchanged to the engine
//  WIDTH_B  16   operand B width; must be a power of two because the engine's ready timing assumes it
//  TIMEOUT  255  max cycles in WAIT before abort, 1..65535
//  WIDTH_Y is derived: WIDTH_A+WIDTH_B
// PORTS
//  clk_i        in   1              system clock
//  nreset_i     in   1              asynchronous, active-low reset
//  req_i        in   N_REQ          request level per requester
//  a_i          in   N_REQ*WIDTH_A  packed A operands; requester k at [k*WIDTH_A +: WIDTH_A]
//  b_i          in   N_REQ*WIDTH_B  packed B operands, same packing
//  ack_o        out  N_REQ          one-cycle one-hot pulse: operands of that requester captured
//  valid_o      out  N_REQ          one-cycle one-hot pulse: y_o holds that requester's product
//  err_o        out  1              one-cycle pulse coincident with valid_o on timeout abort
//  y_o          out  WIDTH_Y        last product; held until next valid_o
//  busy_o       out  1              high in every state except IDLE
//  mul_start_o  out  1              engine start, registered one-cycle pulse
//  mul_a_o      out  WIDTH_A        engine A operand, registered, stable from START through WAIT
//  mul_b_o      out  WIDTH_B        engine B operand, registered, same stability rule
//  mul_y_i      in   WIDTH_Y        engine product
//  mul_rdy_i    in   1              engine ready; may be stale-high during the cycle after start
// BEHAVIOUR
//  Reset (async, nreset_i=0): state=IDLE; all outputs 0; rr pointer=N_REQ-1, so index 0 has first priority.
//  FSM states:
//   IDLE: if |req_i, grant g = first set req after the pointer (wrapping), checked on the same edge.
//         Capture a/b[g] into mul_a_o/mul_b_o; ack_o[g]=1; pointer<=g; next state START.
//   START: mul_start_o=1 for exactly one cycle; next state GUARD.
//   GUARD: mul_rdy_i is ignored (stale value from the previous op); clear the timeout counter; next state WAIT.
//   WAIT: on mul_rdy_i=1: y_o<=mul_y_i; valid_o[g]=1; next state IDLE.
//         Else if counter==TIMEOUT: y_o<=0; valid_o[g]=1; err_o=1; next state IDLE.
//         Else counter+1.
//  Latency: req visible in IDLE -> ack_o on next edge; valid_o = 3 + 2^clog2(WIDTH_B) cycles after ack.
//  Back-to-back operation: a new grant is made in the same IDLE cycle that follows valid_o. No idle bubble beyond IDLE itself.
//  Fairness: the requester just served has lowest priority on the next grant.
//   A requester holding req_i high continuously is served at most once per round.
//  req_i deasserted after ack_o: no effect; the operation completes and valid_o is still issued.
//  req_i deasserted before grant: no ack; nothing is latched.
//  Operands and result: passed through bit-exact, no truncation or saturation; product is WIDTH_Y bits.
//  Reset mid-operation: FSM to IDLE immediately; no valid_o is issued.
//   The engine has no reset, so its result is discarded; the next START re-initialises the engine.
//  ack_o, valid_o and err_o never assert for more than one requester in the same cycle.
// STRUCTURE
//  Shared include (global-defines file) holds:
//   - FSM state encodings ST_IDLE..ST_WAIT (3-bit)
//   - default widths
//   - macro for the engine latency 2^clog2(WIDTH_B)
//  Sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot grant, index, any).
//  Parent holds FSM, operand/result registers and the timeout counter.
//  Engine is instantiated outside this block and connected via mul_* ports.
// TESTING
//  1. Single req_i=4'b0100, a=-3, b=7 -> ack_o[2] next edge; valid_o[2] 3+16 cycles later; y_o=-21.
//  2. req_i=4'b1111 held -> grants in order 0,1,2,3,0; each valid_o one-hot.
//     No ack while busy_o=1.
//  3. Stale ready: mul_rdy_i high before and during GUARD -> no early valid_o.
//     Completion only on mul_rdy_i in WAIT.
//  4. Engine model never raises ready, TIMEOUT=20 -> valid_o and err_o pulse 21 cycles after entering WAIT.
//     y_o=0; next grant proceeds.
//  5. nreset_i low during WAIT -> all outputs 0 asynchronously; after release, req_i[1] completes normally.
//  6. req_i[3] pulsed one cycle while IDLE with req_i[0] also high -> only requester 0 granted.
//     Requester 3 is not acked later.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   - default parameter values
//   - 3-bit FSM state encoding
//   - engine latency helper: the serial engine takes 2^clog2(WIDTH_B) steps
package mul_share_arbiter_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH_A = 16;
    localparam int DEF_WIDTH_B = 16;
    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 16;   // covers TIMEOUT up to 65535

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3
    } state_t;

    function automatic int eng_latency(input int width_b);
        return 1 << $clog2(width_b);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the arbiter.
//   req_i/a_i/b_i          : requester levels and packed operands
//   ack_o/valid_o/err_o    : one-hot capture / result pulses, abort flag
//   y_o/busy_o             : held product, non-IDLE indicator
//   mul_start_o/a_o/b_o    : engine start pulse and operands
//   mul_y_i/mul_rdy_i      : engine product and ready
// Modports: slave = the arbiter, master = requesters plus engine.
interface mul_share_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16
);
    localparam int WIDTH_Y = WIDTH_A + WIDTH_B;

    logic [N_REQ-1:0]         req_i;
    logic [N_REQ*WIDTH_A-1:0] a_i;
    logic [N_REQ*WIDTH_B-1:0] b_i;
    logic [N_REQ-1:0]         ack_o;
    logic [N_REQ-1:0]         valid_o;
    logic                     err_o;
    logic [WIDTH_Y-1:0]       y_o;
    logic                     busy_o;
    logic                     mul_start_o;
    logic [WIDTH_A-1:0]       mul_a_o;
    logic [WIDTH_B-1:0]       mul_b_o;
    logic [WIDTH_Y-1:0]       mul_y_i;
    logic                     mul_rdy_i;

    modport slave (
        input  req_i, a_i, b_i, mul_y_i, mul_rdy_i,
        output ack_o, valid_o, err_o, y_o, busy_o, mul_start_o, mul_a_o, mul_b_o
    );

    modport master (
        output req_i, a_i, b_i, mul_y_i, mul_rdy_i,
        input  ack_o, valid_o, err_o, y_o, busy_o, mul_start_o, mul_a_o, mul_b_o
    );

endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request levels
//   ptr : index of the last requester served (lowest priority now)
//   gnt : one-hot grant, idx : its index, any : some request is set
module mul_share_arbiter_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        // Scan starting just after ptr; ptr itself is visited last.
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!any && req[k]) begin
                any    = 1'b1;
                idx    = IDX_W'(k);
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one serial signed multiplier among N_REQ
// requesters. Grants in IDLE, pulses the engine start, skips the stale
// ready cycle, then waits for ready or aborts after TIMEOUT cycles.
//   clk_i, nreset_i : clock, async active-low reset
//   bus             : requester + engine signals (slave modport)
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    mul_share_arbiter_if.slave bus
);

    localparam int WIDTH_Y = WIDTH_A + WIDTH_B;
    localparam int IDX_W   = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [N_REQ-1:0]   ack_d, valid_d;
    logic               err_d, start_d, load_op, load_y, cnt_clr, cnt_inc;
    logic [WIDTH_Y-1:0] y_d;

    mul_share_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        valid_d = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        load_op = 1'b0;
        load_y  = 1'b0;
        y_d     = '0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    ack_d   = pick_gnt;
                    start_d = 1'b1;   // start is high while in START
                    load_op = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_GUARD;
            ST_GUARD: begin
                // Ready still reflects the previous operation here.
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mul_rdy_i) begin
                    y_d     = bus.mul_y_i;
                    load_y  = 1'b1;
                    valid_d = gnt_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    load_y  = 1'b1;
                    valid_d = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            ptr_q           <= IDX_W'(N_REQ - 1);
            gnt_q           <= '0;
            cnt_q           <= '0;
            bus.ack_o       <= '0;
            bus.valid_o     <= '0;
            bus.err_o       <= 1'b0;
            bus.y_o         <= '0;
            bus.mul_start_o <= 1'b0;
            bus.mul_a_o     <= '0;
            bus.mul_b_o     <= '0;
        end else begin
            bus.ack_o       <= ack_d;
            bus.valid_o     <= valid_d;
            bus.err_o       <= err_d;
            bus.mul_start_o <= start_d;
            if (load_op) begin
                bus.mul_a_o <= bus.a_i[pick_idx*WIDTH_A +: WIDTH_A];
                bus.mul_b_o <= bus.b_i[pick_idx*WIDTH_B +: WIDTH_B];
                ptr_q       <= pick_idx;
                gnt_q       <= pick_gnt;
            end
            if (load_y) bus.y_o <= y_d;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter. A behavioural model predicts
// grant order, pulse timing and products from the round-robin rules; a
// small engine model supplies ready/product with optional stale or dead ready.
module tb_mul_share_arbiter;
    import mul_share_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int WA = 16;
    localparam int WB = 16;
    localparam int WY = WA + WB;
    localparam int TO = 20;
    localparam int L  = eng_latency(WB);

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();

    mul_share_arbiter #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .TIMEOUT(TO)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- engine model: load cycle + L shift steps ----------------
    logic          eng_dead  = 1'b0;
    logic          eng_stale = 1'b0;
    logic          e_rdy     = 1'b0;
    logic          e_kill    = 1'b0;
    int            e_cnt     = 0;
    logic [WY-1:0] e_prod    = '0;

    assign bus.mul_rdy_i = e_rdy;
    assign bus.mul_y_i   = e_prod;

    always @(posedge clk) begin
        if (bus.mul_start_o) begin
            e_cnt  <= L + 1;
            e_prod <= WY'($signed(bus.mul_a_o)) * WY'($signed(bus.mul_b_o));
            if (!eng_stale) e_rdy <= 1'b0;
            e_kill <= eng_stale;
        end else begin
            if (e_kill) begin
                e_rdy  <= 1'b0;
                e_kill <= 1'b0;
            end
            if (e_cnt > 0) begin
                e_cnt <= e_cnt - 1;
                if (e_cnt == 1 && !eng_dead) e_rdy <= 1'b1;
            end
        end
    end

    // ---------------- reference model + per-cycle monitor ----------------
    logic                 m_busy = 1'b0;
    int                   m_ptr  = N - 1;
    int                   m_g    = 0;
    int                   m_t    = 0;
    logic                 m_dead = 1'b0;
    logic [WA-1:0]        m_a    = '0;
    logic [WB-1:0]        m_b    = '0;
    logic signed [WY-1:0] m_p    = '0;
    logic [WY-1:0]        m_y    = '0;
    logic [N-1:0]         e_ack, e_valid;
    logic                 e_err, e_start;
    logic [N-1:0]         s_req;
    logic [N*WA-1:0]      s_a;
    logic [N*WB-1:0]      s_b;
    logic                 s_rst;
    int                   cyc = 0;
    int                   n_ack = 0, n_ack3 = 0, n_errs = 0;
    int                   last_ack_cyc = 0, last_val_cyc = 0;
    int                   act_log[$];

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++)
            if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    always begin
        @(posedge clk);
        cyc++;
        s_req = bus.req_i; s_a = bus.a_i; s_b = bus.b_i; s_rst = nreset;
        e_ack = '0; e_valid = '0; e_err = 1'b0; e_start = 1'b0;
        if (!s_rst) begin
            m_busy = 1'b0; m_ptr = N - 1; m_y = '0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == (m_dead ? 3 + TO : 3 + L)) begin
                e_valid[m_g] = 1'b1;
                e_err        = m_dead;
                m_y          = m_dead ? '0 : m_p;
                m_busy       = 1'b0;
            end
        end else if (s_req != '0) begin
            m_g      = rr_next(s_req, m_ptr);
            m_ptr    = m_g;
            e_ack[m_g] = 1'b1;
            e_start  = 1'b1;
            m_busy   = 1'b1;
            m_t      = 0;
            m_dead   = eng_dead;
            m_a      = s_a[m_g*WA +: WA];
            m_b      = s_b[m_g*WB +: WB];
            m_p      = WY'($signed(m_a)) * WY'($signed(m_b));
        end
        #1;
        chk("ack",   bus.ack_o,       e_ack);
        chk("valid", bus.valid_o,     e_valid);
        chk("err",   bus.err_o,       e_err);
        chk("y",     bus.y_o,         m_y);
        chk("busy",  bus.busy_o,      m_busy);
        chk("start", bus.mul_start_o, e_start);
        if (m_busy) begin
            chk("mul_a", bus.mul_a_o, m_a);
            chk("mul_b", bus.mul_b_o, m_b);
        end
        for (int i = 0; i < N; i++)
            if (bus.ack_o[i]) act_log.push_back(i);
        if (|bus.ack_o)   begin n_ack++; last_ack_cyc = cyc; end
        if (bus.ack_o[3]) n_ack3++;
        if (|bus.valid_o) last_val_cyc = cyc;
        if (bus.err_o)    n_errs++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic rand_ops();
        bus.a_i = {$urandom(), $urandom()};
        bus.b_i = {$urandom(), $urandom()};
    endtask

    task automatic wait_ack(input int max_cyc);
        int base = n_ack;
        int n = 0;
        while (n_ack == base && n < max_cyc) begin @(negedge clk); n++; end
        chk("ack_wait", 64'(n_ack != base), 64'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (m_busy && n < max_cyc) begin @(negedge clk); n++; end
        chk("idle_wait", 64'(m_busy), 64'd0);
    endtask

    task automatic do_op(input logic [N-1:0] r);
        @(negedge clk);
        rand_ops();
        bus.req_i = r;
        wait_ack(40);
        bus.req_i = '0;
        wait_idle(60);
    endtask

    task automatic rst_pulse();
        @(negedge clk); nreset = 1'b0;
        @(negedge clk); nreset = 1'b1;
    endtask

    int exp2[5] = '{0, 1, 2, 3, 0};
    int base3;

    initial begin
        bus.req_i = '0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        #1;
        chk("rst_ack",   bus.ack_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_busy",  bus.busy_o, 0);
        chk("rst_y",     bus.y_o, 0);
        @(negedge clk); nreset = 1'b1;

        // T1: single request, signed product
        @(negedge clk);
        rand_ops();
        bus.a_i[2*WA +: WA] = 16'hFFFD;   // -3
        bus.b_i[2*WB +: WB] = 16'd7;
        bus.req_i = 4'b0100;
        wait_ack(5);
        bus.req_i = '0;                   // drop after ack: op still completes
        wait_idle(40);
        chk("t1_y",   bus.y_o, 64'(32'hFFFF_FFEB));
        chk("t1_lat", 64'(last_val_cyc - last_ack_cyc), 64'(3 + L));

        // T2: all requesting from reset -> 0,1,2,3,0
        rst_pulse();
        act_log.delete();
        @(negedge clk);
        bus.req_i = 4'b1111;
        for (int n = 0; n < 200 && act_log.size() < 5; n++) begin
            @(negedge clk);
            rand_ops();
        end
        bus.req_i = '0;
        wait_idle(60);
        chk("t2_cnt", 64'(act_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < act_log.size(); i++)
            chk("t2_order", 64'(act_log[i]), 64'(exp2[i]));

        // T3: stale ready through START and GUARD
        eng_stale = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(4'(1 << $urandom_range(0, N - 1)));
            chk("t3_lat", 64'(last_val_cyc - last_ack_cyc), 64'(3 + L));
        end
        eng_stale = 1'b0;

        // T4: dead engine -> timeout abort, then normal grant
        eng_dead = 1'b1;
        base3 = n_errs;
        do_op(4'b0010);
        chk("t4_lat",  64'(last_val_cyc - last_ack_cyc), 64'(3 + TO));
        chk("t4_errs", 64'(n_errs - base3), 64'd1);
        chk("t4_y",    bus.y_o, 0);
        eng_dead = 1'b0;
        do_op(4'b0001);
        chk("t4_next", 64'(last_val_cyc - last_ack_cyc), 64'(3 + L));

        // T5: reset while in WAIT
        @(negedge clk);
        rand_ops();
        bus.req_i = 4'b0010;
        for (int n = 0; n < 40 && !(m_busy && m_t >= 5); n++) @(negedge clk);
        chk("t5_in_wait", 64'(m_busy), 64'd1);
        nreset = 1'b0;
        #1;
        chk("t5_ack",   bus.ack_o, 0);
        chk("t5_valid", bus.valid_o, 0);
        chk("t5_err",   bus.err_o, 0);
        chk("t5_y",     bus.y_o, 0);
        chk("t5_busy",  bus.busy_o, 0);
        chk("t5_start", bus.mul_start_o, 0);
        chk("t5_mul_a", bus.mul_a_o, 0);
        chk("t5_mul_b", bus.mul_b_o, 0);
        @(negedge clk); @(negedge clk);
        nreset = 1'b1;
        wait_ack(5);
        chk("t5_gnt1", 64'(act_log[$]), 64'd1);
        bus.req_i = '0;
        wait_idle(40);

        // T6: req[3] pulsed one cycle alongside req[0]
        rst_pulse();
        base3 = n_ack3;
        @(negedge clk);
        bus.req_i = 4'b1001;
        @(negedge clk);
        bus.req_i = '0;
        wait_idle(40);
        repeat (10) @(negedge clk);
        chk("t6_gnt0",    64'(act_log[$]), 64'd0);
        chk("t6_no_ack3", 64'(n_ack3 - base3), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rand_ops();
            bus.req_i = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            eng_stale = 1'($urandom_range(0, 1));
        end
        bus.req_i = '0;
        wait_idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
